smem_output_arbiter: RTL and testbench
======================================

// Module: smem_output_arbiter
// PURPOSE
//  Shares one 512-bit result channel between NUM_PORTS curr/mem result RAM banks. Each bank
//  raises output_request when its batch completes. The arbiter grants output_permit to one bank
//  at a time in round-robin order and forwards that bank's beats downstream with one-cycle
//  registered latency. A grant is held until the bank's sticky output_finish. When every
//  enabled bank has finished, all_done is raised. Sits between the RAM banks and the host
//  write-back path.
// PARAMETERS
//  NUM_PORTS  4    number of result RAM banks (>=2)
//  IDX_W      2    clog2(NUM_PORTS); width of grant index
//  DATA_W     512  beat width
//  CNT_W      16   width of beat counter
// PORTS
//  clk          in   1                    system clock, all logic on posedge
//  reset        in   1                    synchronous, active-high reset
//  batch_start  in   1                    1-cycle pulse: clear served mask, counters, all_done
//  port_enable  in   NUM_PORTS            banks taking part in this batch (static during batch)
//  req          in   NUM_PORTS            output_request from each bank
//  permit       out  NUM_PORTS            output_permit to each bank (one-hot or zero)
//  in_data      in   NUM_PORTS*DATA_W     output_data of each bank, bank i at [i*DATA_W +: DATA_W]
//  in_valid     in   NUM_PORTS            output_valid of each bank
//  in_finish    in   NUM_PORTS            output_finish of each bank (sticky until bank reset)
//  out_data     out  DATA_W               forwarded beat
//  out_valid    out  1                    out_data valid this cycle
//  out_port     out  IDX_W                bank index of the current out_data beat
//  beat_count   out  CNT_W                forwarded beats since batch_start
//  all_done     out  1                    every enabled bank served; sticky
// BEHAVIOUR
//  Reset values: permit=0, out_data=0, out_valid=0, out_port=0, beat_count=0, all_done=0.
//  Internal reset values: served=0, rr_ptr=0, state=IDLE.
//  Reset mid-transfer drops permit on the same edge. Beats in flight are discarded.
//  State machine (registered state):
//   IDLE:  cand = req & port_enable & ~served.
//          - cand!=0: pick the first set bit searching upward from rr_ptr, wrapping at
//            NUM_PORTS-1 -> 0. Set g to that bit, set permit[g]=1, go GRANT.
//            permit is therefore high 1 cycle after req is seen.
//          - cand==0 and port_enable!=0 and (served & port_enable)==port_enable:
//            set all_done=1, go DONE.
//   GRANT: out_valid <= in_valid[g].
//          - On a valid beat: out_data <= in_data[g], out_port <= g, beat_count += 1
//            (wraps modulo 2^CNT_W). Otherwise out_data holds its value.
//          - in_valid/in_finish of non-granted banks are ignored.
//          - in_finish[g]==1: permit <= 0, served[g] <= 1, rr_ptr <= g+1 (wrap), go GAP.
//            A beat arriving with finish in that same cycle is still forwarded.
//   GAP:   1 cycle, permit=0, out_valid follows the last registered beat then 0. Go IDLE.
//          Guarantees no two permits overlap and every bank sees permit low before the next.
//   DONE:  permit=0, out_valid=0. Leave only on batch_start or reset.
//  batch_start (any state): served=0, beat_count=0, all_done=0, permit=0, rr_ptr=0, go IDLE.
//   batch_start outranks a simultaneous in_finish or a new grant.
//   beat_count ignores any beat in that cycle.
//  A bank whose req drops while granted keeps permit until in_finish. Banks cannot withdraw.
//  A bank asserting in_finish before being granted is not marked served until granted.
//  port_enable==0: never grants, all_done stays 0.
//  Downstream stall is handled inside the banks. The arbiter forwards gaps in in_valid unchanged.
//  Invariants: $onehot0(permit) every cycle; out_valid implies previous-cycle permit[out_port].
// TESTING
//  1 Reset: hold reset 3 cycles with req=4'b1111 -> permit=0, out_valid=0, all_done=0 throughout.
//  2 Single bank: enable=4'b0100; req[2] rises at cycle 10 -> permit=4'b0100 at cycle 11.
//    Bank sends 5 beats, then finish -> out_port=2, beat_count=5, permit low next cycle,
//    all_done=1 two cycles later.
//  3 Round-robin: enable=4'b1111, all req high, each bank sends 3 beats then finish.
//    -> grant order 0,1,2,3, never two permit bits high, beat_count=12, all_done=1.
//  4 Wrap: after serving bank 2 (rr_ptr=3) only req[1] and req[3] pending.
//    -> bank 3 granted before bank 1.
//  5 Edge events: finish with a beat in the same cycle -> beat forwarded, counted.
//    batch_start coincident with in_finish[g] -> served=0, permit=0, beat_count=0, state IDLE.
//  6 Reset mid-transfer: assert reset during the 2nd beat of bank 1 -> permit=0 that edge.
//    Re-run after reset -> bank 1 regranted, beat_count counts from 0.

Source files
------------

// File: rtl/smem_output_arbiter_if.sv
// smem_output_arbiter_if: bank-side and host-side signals of the result channel arbiter
interface smem_output_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2,
    parameter int DATA_W    = 512,
    parameter int CNT_W     = 16
);
    logic                        batch_start;
    logic [NUM_PORTS-1:0]        port_enable;
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        permit;
    logic [NUM_PORTS*DATA_W-1:0] in_data;
    logic [NUM_PORTS-1:0]        in_valid;
    logic [NUM_PORTS-1:0]        in_finish;
    logic [DATA_W-1:0]           out_data;
    logic                        out_valid;
    logic [IDX_W-1:0]            out_port;
    logic [CNT_W-1:0]            beat_count;
    logic                        all_done;
    modport slave (
        input  batch_start, port_enable, req, in_data, in_valid, in_finish,
        output permit, out_data, out_valid, out_port, beat_count, all_done
    );
    modport master (
        output batch_start, port_enable, req, in_data, in_valid, in_finish,
        input  permit, out_data, out_valid, out_port, beat_count, all_done
    );
endinterface

// File: rtl/smem_output_arbiter.sv
// smem_output_arbiter: round-robin sharing of one result channel among RAM banks
module smem_output_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2,
    parameter int DATA_W    = 512,
    parameter int CNT_W     = 16
) (
    input logic                clk,
    input logic                reset,
    smem_output_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     g_q, g_d, rr_ptr_q, rr_ptr_d, out_port_q, out_port_d, pick;
    logic [NUM_PORTS-1:0] permit_q, permit_d, served_q, served_d, cand, cand_hi, sel;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d, all_done_q, all_done_d;
    logic [CNT_W-1:0]     beat_count_q, beat_count_d;

    assign bus.permit     = permit_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_port   = out_port_q;
    assign bus.beat_count = beat_count_q;
    assign bus.all_done   = all_done_q;

    // Round-robin pick: lowest candidate at or above rr_ptr, else lowest overall
    always_comb begin
        cand    = bus.req & bus.port_enable & ~served_q;
        cand_hi = cand & ~((NUM_PORTS'(1) << rr_ptr_q) - NUM_PORTS'(1));
        sel     = (cand_hi != '0) ? cand_hi : cand;
        pick    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (sel[i]) pick = IDX_W'(i);
    end

    // Next-state and registered-output logic; batch_start overrides everything
    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        rr_ptr_d     = rr_ptr_q;
        permit_d     = '0;
        served_d     = served_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        out_port_d   = out_port_q;
        beat_count_d = beat_count_q;
        all_done_d   = all_done_q;
        case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    g_d      = pick;
                    permit_d = sel & (~sel + NUM_PORTS'(1));
                    state_d  = GRANT;
                end else if (bus.port_enable != '0 &&
                             (served_q & bus.port_enable) == bus.port_enable) begin
                    all_done_d = 1'b1;
                    state_d    = DONE;
                end
            end
            GRANT: begin
                permit_d    = permit_q;
                out_valid_d = bus.in_valid[g_q];
                if (bus.in_valid[g_q]) begin
                    out_data_d   = bus.in_data[g_q*DATA_W +: DATA_W];
                    out_port_d   = g_q;
                    beat_count_d = beat_count_q + CNT_W'(1);
                end
                if (bus.in_finish[g_q]) begin
                    permit_d     = '0;
                    served_d[g_q] = 1'b1;
                    rr_ptr_d     = (g_q == IDX_W'(NUM_PORTS - 1)) ? '0 : g_q + IDX_W'(1);
                    state_d      = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = DONE;
        endcase
        if (bus.batch_start) begin
            state_d      = IDLE;
            permit_d     = '0;
            served_d     = '0;
            rr_ptr_d     = '0;
            out_valid_d  = 1'b0;
            beat_count_d = '0;
            all_done_d   = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            g_q          <= '0;
            rr_ptr_q     <= '0;
            permit_q     <= '0;
            served_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_port_q   <= '0;
            beat_count_q <= '0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            rr_ptr_q     <= rr_ptr_d;
            permit_q     <= permit_d;
            served_q     <= served_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_port_q   <= out_port_d;
            beat_count_q <= beat_count_d;
            all_done_q   <= all_done_d;
        end
    end
endmodule

// File: tb/tb_smem_output_arbiter.sv
// tb_smem_output_arbiter: directed checks of grant order, forwarding, batch control and reset
module tb_smem_output_arbiter;
    localparam int NP = 4, IW = 2, DW = 512, CW = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0, errors = 0;
    int   exp_cnt = 0;

    smem_output_arbiter_if #(.NUM_PORTS(NP), .IDX_W(IW), .DATA_W(DW), .CNT_W(CW)) bus ();

    smem_output_arbiter #(.NUM_PORTS(NP), .IDX_W(IW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dval(input int b, input int j);
        return 64'hC0DE_0000_0000_0000 | (64'(b) << 32) | 64'(j * 7 + 3);
    endfunction

    // Bank b sends n beats; finish arrives with the last beat or on a separate cycle
    task automatic serve(input int b, input int n, input bit fin_last);
        for (int j = 0; j < n; j++) begin
            bus.in_valid[b] = 1'b1;
            bus.in_data[b*DW +: DW] = DW'(dval(b, j));
            bus.in_finish[b] = fin_last && (j == n - 1);
            tick();
            exp_cnt = (exp_cnt + 1) % 65536;
            chk($sformatf("b%0d_valid%0d", b, j), 64'(bus.out_valid), 64'd1);
            chk($sformatf("b%0d_data%0d", b, j), bus.out_data[63:0], dval(b, j));
            chk($sformatf("b%0d_port%0d", b, j), 64'(bus.out_port), 64'(b));
            chk($sformatf("b%0d_cnt%0d", b, j), 64'(bus.beat_count), 64'(exp_cnt));
            chk($sformatf("b%0d_permit%0d", b, j), 64'(bus.permit),
                (fin_last && j == n - 1) ? 64'd0 : 64'(1 << b));
        end
        bus.in_valid[b] = 1'b0;
        if (!fin_last) begin
            bus.in_finish[b] = 1'b1;
            tick();
            chk($sformatf("b%0d_fin_permit", b), 64'(bus.permit), 64'd0);
            chk($sformatf("b%0d_fin_valid", b), 64'(bus.out_valid), 64'd0);
            chk($sformatf("b%0d_fin_cnt", b), 64'(bus.beat_count), 64'(exp_cnt));
            chk($sformatf("b%0d_fin_port", b), 64'(bus.out_port), 64'(b));
        end
        tick();
        chk($sformatf("b%0d_gap_permit", b), 64'(bus.permit), 64'd0);
        chk($sformatf("b%0d_gap_valid", b), 64'(bus.out_valid), 64'd0);
        chk($sformatf("b%0d_gap_done", b), 64'(bus.all_done), 64'd0);
    endtask

    task automatic start_batch();
        bus.batch_start = 1'b1;
        tick();
        bus.batch_start = 1'b0;
        exp_cnt = 0;
        chk("bs_permit", 64'(bus.permit), 64'd0);
        chk("bs_cnt", 64'(bus.beat_count), 64'd0);
        chk("bs_done", 64'(bus.all_done), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.batch_start = 1'b0;
        bus.port_enable = 4'b1111;
        bus.req = 4'b1111;
        bus.in_data = '0;
        bus.in_valid = '0;
        bus.in_finish = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_permit", 64'(bus.permit), 64'd0);
            chk("rst_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_done", 64'(bus.all_done), 64'd0);
        end
        chk("rst_cnt", 64'(bus.beat_count), 64'd0);
        chk("rst_port", 64'(bus.out_port), 64'd0);
        chk("rst_data", bus.out_data[63:0], 64'd0);
        reset = 1'b0;
        bus.req = '0;

        bus.port_enable = 4'b0100;
        start_batch();
        tick();
        chk("single_idle_permit", 64'(bus.permit), 64'd0);
        bus.req = 4'b0100;
        tick();
        chk("single_grant", 64'(bus.permit), 64'b0100);
        serve(2, 5, 1'b0);
        tick();
        chk("single_done", 64'(bus.all_done), 64'd1);
        chk("single_cnt", 64'(bus.beat_count), 64'd5);

        bus.in_finish = '0;
        bus.port_enable = 4'b1111;
        bus.req = 4'b1111;
        start_batch();
        for (int b = 0; b < 4; b++) begin
            tick();
            chk($sformatf("rr_grant%0d", b), 64'(bus.permit), 64'(1 << b));
            serve(b, 3, 1'b1);
        end
        tick();
        chk("rr_done", 64'(bus.all_done), 64'd1);
        chk("rr_cnt", 64'(bus.beat_count), 64'd12);
        chk("rr_permit_off", 64'(bus.permit), 64'd0);

        bus.in_finish = '0;
        bus.req = '0;
        start_batch();
        bus.req = 4'b0100;
        tick();
        chk("wrap_first", 64'(bus.permit), 64'b0100);
        serve(2, 2, 1'b1);
        bus.req = 4'b1010;
        tick();
        chk("wrap_b3_first", 64'(bus.permit), 64'b1000);
        serve(3, 1, 1'b1);
        tick();
        chk("wrap_b1_next", 64'(bus.permit), 64'b0010);
        serve(1, 1, 1'b1);
        tick();
        chk("wrap_not_done", 64'(bus.all_done), 64'd0);
        bus.req = 4'b0001;
        tick();
        chk("wrap_b0", 64'(bus.permit), 64'b0001);
        serve(0, 1, 1'b1);
        tick();
        chk("wrap_done", 64'(bus.all_done), 64'd1);

        bus.in_finish = '0;
        bus.req = '0;
        bus.port_enable = 4'b0011;
        start_batch();
        bus.req = 4'b0011;
        tick();
        chk("edge_grant", 64'(bus.permit), 64'b0001);
        bus.in_valid = 4'b0001;
        bus.in_data[63:0] = 64'h55;
        tick();
        chk("edge_cnt1", 64'(bus.beat_count), 64'd1);
        bus.in_finish = 4'b0001;
        bus.batch_start = 1'b1;
        tick();
        chk("edge_bs_permit", 64'(bus.permit), 64'd0);
        chk("edge_bs_cnt", 64'(bus.beat_count), 64'd0);
        chk("edge_bs_done", 64'(bus.all_done), 64'd0);
        bus.batch_start = 1'b0;
        bus.in_valid = '0;
        bus.in_finish = '0;
        exp_cnt = 0;
        tick();
        chk("edge_regrant", 64'(bus.permit), 64'b0001);
        serve(0, 1, 1'b1);
        tick();
        chk("mid_grant1", 64'(bus.permit), 64'b0010);
        bus.in_valid = 4'b0010;
        bus.in_data[DW +: DW] = DW'(64'h77);
        tick();
        chk("mid_beat1_cnt", 64'(bus.beat_count), 64'd2);
        chk("mid_beat1_port", 64'(bus.out_port), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_permit", 64'(bus.permit), 64'd0);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_cnt", 64'(bus.beat_count), 64'd0);
        reset = 1'b0;
        bus.in_valid = '0;
        bus.in_finish = '0;
        bus.req = 4'b0010;
        exp_cnt = 0;
        tick();
        chk("mid_regrant", 64'(bus.permit), 64'b0010);
        serve(1, 2, 1'b1);
        tick();
        chk("mid_not_done", 64'(bus.all_done), 64'd0);

        bus.port_enable = '0;
        bus.req = 4'b1111;
        start_batch();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("noen_permit", 64'(bus.permit), 64'd0);
            chk("noen_done", 64'(bus.all_done), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(negedge clk)
        if (!reset) begin
            checks++;
            assert ($onehot0(bus.permit))
            else begin
                errors++;
                $error("FAIL onehot0 observed %b expected at most one bit", bus.permit);
            end
        end
endmodule
